// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: destination-register tag layout and the bubble value.
// The tag is packed as {valid, rd, used, memory}; bit offsets are exposed for width-generic users.
package pipeline_pkg;

   localparam int PIPE_REG_W   = 5;

   localparam int TAG_MEM_BIT  = 0;
   localparam int TAG_USED_BIT = 1;
   localparam int TAG_RD_LSB   = 2;

   function automatic int tag_width(input int reg_w);
      return reg_w + 3;
   endfunction

   function automatic int tag_valid_bit(input int reg_w);
      return reg_w + 2;
   endfunction

   typedef struct packed {
      logic                  valid;
      logic [PIPE_REG_W-1:0] rd;
      logic                  used;
      logic                  memory;
   } rd_tag_t;

   localparam rd_tag_t BUBBLE = '0;

endpackage

// File: rtl/rd_tag_stage.sv
// One pipeline tag register: reset, then flush, then hold, then bubble insert, then load.
// Flush deliberately outranks a deasserted enable so a stalled stage can still be squashed.
module rd_tag_stage
   import pipeline_pkg::*;
#(
   parameter int TAG_W = tag_width(PIPE_REG_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             ena,
   input  logic             nop,
   input  logic [TAG_W-1:0] tag_in,
   output logic [TAG_W-1:0] tag_out
);

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_out <= '0;
      end else if (flush) begin
         tag_out <= '0;
      end else if (ena) begin
         tag_out <= nop ? '0 : tag_in;
      end
   end

endmodule

// File: rtl/pipeline_rd_tracker.sv
// Carries destination-register tags from DEC through OP/EX/MEM/WB and exposes the hazard and write-back
// fields, plus saturating stall and bubble counters for performance monitoring.
module pipeline_rd_tracker
   import pipeline_pkg::*;
#(
   parameter int REG_W = PIPE_REG_W,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] rd_dec,
   input  logic             rd_used_dec,
   input  logic             rd_memory_dec,
   input  logic             valid_dec,
   input  logic             flush,
   input  logic             dec_ena,
   input  logic             op_ena,
   input  logic             ex_ena,
   input  logic             mem_ena,
   input  logic             wb_ena,
   input  logic             dec_nop,
   input  logic             op_nop,
   input  logic             ex_nop,
   input  logic             mem_nop,
   output logic [REG_W-1:0] rd_op,
   output logic [REG_W-1:0] rd_ex,
   output logic [REG_W-1:0] rd_mem,
   output logic [REG_W-1:0] rd_wb,
   output logic             rd_used_op,
   output logic             rd_used_ex,
   output logic             rd_memory_op,
   output logic             rd_memory_mem,
   output logic             rd_we_wb,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] bubble_count
);

   localparam int TW  = tag_width(REG_W);
   localparam int VB  = tag_valid_bit(REG_W);
   localparam int RDM = TAG_RD_LSB + REG_W - 1;

   logic [TW-1:0] tag_dec, tag_op, tag_ex, tag_mem, tag_wb;

   assign tag_dec = {valid_dec, rd_dec, rd_used_dec, rd_memory_dec};

   rd_tag_stage #(.TAG_W(TW)) u_op (
      .clk(clk), .rst(rst), .flush(flush), .ena(op_ena), .nop(dec_nop),
      .tag_in(tag_dec), .tag_out(tag_op));

   rd_tag_stage #(.TAG_W(TW)) u_ex (
      .clk(clk), .rst(rst), .flush(flush), .ena(ex_ena), .nop(op_nop),
      .tag_in(tag_op), .tag_out(tag_ex));

   rd_tag_stage #(.TAG_W(TW)) u_mem (
      .clk(clk), .rst(rst), .flush(1'b0), .ena(mem_ena), .nop(ex_nop),
      .tag_in(tag_ex), .tag_out(tag_mem));

   rd_tag_stage #(.TAG_W(TW)) u_wb (
      .clk(clk), .rst(rst), .flush(1'b0), .ena(wb_ena), .nop(mem_nop),
      .tag_in(tag_mem), .tag_out(tag_wb));

   assign rd_op  = tag_op[RDM:TAG_RD_LSB];
   assign rd_ex  = tag_ex[RDM:TAG_RD_LSB];
   assign rd_mem = tag_mem[RDM:TAG_RD_LSB];
   assign rd_wb  = tag_wb[RDM:TAG_RD_LSB];

   // Flags read as zero for an invalid tag even if DEC presented stray flag bits.
   assign rd_used_op    = tag_op[VB]  & tag_op[TAG_USED_BIT];
   assign rd_used_ex    = tag_ex[VB]  & tag_ex[TAG_USED_BIT];
   assign rd_memory_op  = tag_op[VB]  & tag_op[TAG_MEM_BIT];
   assign rd_memory_mem = tag_mem[VB] & tag_mem[TAG_MEM_BIT];

   assign rd_we_wb = tag_wb[VB] & (tag_wb[TAG_USED_BIT] | tag_wb[TAG_MEM_BIT]) & (rd_wb != '0);

   logic unused_tag_bits;
   assign unused_tag_bits = ^{tag_ex[TAG_MEM_BIT], tag_mem[TAG_USED_BIT]};

   logic [1:0]     bubble_inc;
   logic [CNT_W:0] stall_sum;
   logic [CNT_W:0] bubble_sum;
   logic [CNT_W-1:0] stall_next;
   logic [CNT_W-1:0] bubble_next;

   always_comb begin
      bubble_inc  = {1'b0, dec_nop & op_ena} + {1'b0, op_nop & ex_ena};
      stall_sum   = {1'b0, stall_cycles} + (CNT_W+1)'(!dec_ena);
      bubble_sum  = {1'b0, bubble_count} + (CNT_W+1)'(bubble_inc);
      stall_next  = stall_sum[CNT_W]  ? '1 : stall_sum[CNT_W-1:0];
      bubble_next = bubble_sum[CNT_W] ? '1 : bubble_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
         bubble_count <= '0;
      end else begin
         stall_cycles <= stall_next;
         bubble_count <= bubble_next;
      end
   end

endmodule

// File: tb/tb_pipeline_rd_tracker.sv
// Directed bench for pipeline_rd_tracker: flow, stalls, flush, x0 masking and counter saturation.
// A second instance with narrow counters exercises saturation.
module tb_pipeline_rd_tracker;
   import pipeline_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rd_dec;
   logic       rd_used_dec, rd_memory_dec, valid_dec, flush;
   logic       dec_ena, op_ena, ex_ena, mem_ena, wb_ena;
   logic       dec_nop, op_nop, ex_nop, mem_nop;

   logic [4:0]  rd_op, rd_ex, rd_mem, rd_wb;
   logic        rd_used_op, rd_used_ex, rd_memory_op, rd_memory_mem, rd_we_wb;
   logic [31:0] stall_cycles, bubble_count;

   logic [4:0]  s_rd_op, s_rd_ex, s_rd_mem, s_rd_wb;
   logic        s_used_op, s_used_ex, s_mem_op, s_mem_mem, s_we_wb;
   logic [3:0]  s_stall, s_bubble;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   pipeline_rd_tracker #(.REG_W(5), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .rd_dec(rd_dec), .rd_used_dec(rd_used_dec),
      .rd_memory_dec(rd_memory_dec), .valid_dec(valid_dec), .flush(flush),
      .dec_ena(dec_ena), .op_ena(op_ena), .ex_ena(ex_ena), .mem_ena(mem_ena), .wb_ena(wb_ena),
      .dec_nop(dec_nop), .op_nop(op_nop), .ex_nop(ex_nop), .mem_nop(mem_nop),
      .rd_op(rd_op), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
      .rd_used_op(rd_used_op), .rd_used_ex(rd_used_ex),
      .rd_memory_op(rd_memory_op), .rd_memory_mem(rd_memory_mem), .rd_we_wb(rd_we_wb),
      .stall_cycles(stall_cycles), .bubble_count(bubble_count));

   pipeline_rd_tracker #(.REG_W(5), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .rd_dec(rd_dec), .rd_used_dec(rd_used_dec),
      .rd_memory_dec(rd_memory_dec), .valid_dec(valid_dec), .flush(flush),
      .dec_ena(dec_ena), .op_ena(op_ena), .ex_ena(ex_ena), .mem_ena(mem_ena), .wb_ena(wb_ena),
      .dec_nop(dec_nop), .op_nop(op_nop), .ex_nop(ex_nop), .mem_nop(mem_nop),
      .rd_op(s_rd_op), .rd_ex(s_rd_ex), .rd_mem(s_rd_mem), .rd_wb(s_rd_wb),
      .rd_used_op(s_used_op), .rd_used_ex(s_used_ex),
      .rd_memory_op(s_mem_op), .rd_memory_mem(s_mem_mem), .rd_we_wb(s_we_wb),
      .stall_cycles(s_stall), .bubble_count(s_bubble));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rd_dec = '0; rd_used_dec = 0; rd_memory_dec = 0; valid_dec = 0; flush = 0;
      dec_ena = 1; op_ena = 1; ex_ena = 1; mem_ena = 1; wb_ena = 1;
      dec_nop = 0; op_nop = 0; ex_nop = 0; mem_nop = 0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic used, input logic mem);
      rd_dec = rd; rd_used_dec = used; rd_memory_dec = mem; valid_dec = 1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      step();
      step();
      rst = 0;
   endtask

   initial begin
      idle();
      rst = 1;
      #1;

      // 1: reset with random inputs
      for (int i = 0; i < 2; i++) begin
         rd_dec = 5'($urandom); rd_used_dec = 1'($urandom); rd_memory_dec = 1'($urandom);
         valid_dec = 1'($urandom); flush = 1'($urandom);
         dec_ena = 1'($urandom); op_ena = 1'($urandom); ex_ena = 1'($urandom);
         mem_ena = 1'($urandom); wb_ena = 1'($urandom);
         dec_nop = 1'($urandom); op_nop = 1'($urandom); ex_nop = 1'($urandom); mem_nop = 1'($urandom);
         step();
      end
      check("rst_rd", {rd_op, rd_ex, rd_mem, rd_wb}, 0);
      check("rst_flags", {rd_used_op, rd_used_ex, rd_memory_op, rd_memory_mem, rd_we_wb}, 0);
      check("rst_stall", stall_cycles, 0);
      check("rst_bubble", bubble_count, 0);

      // 2: straight flow, 4-cycle latency
      do_reset();
      issue(5, 1, 0);
      step();
      idle();
      check("flow_op", rd_op, 5);
      check("flow_used_op", rd_used_op, 1);
      step();
      check("flow_ex", rd_ex, 5);
      check("flow_used_ex", rd_used_ex, 1);
      step();
      check("flow_mem", rd_mem, 5);
      check("flow_we_early", rd_we_wb, 0);
      step();
      check("flow_wb", rd_wb, 5);
      check("flow_we", rd_we_wb, 1);

      // 3: load-use stall inserts one bubble into OP
      do_reset();
      issue(7, 0, 1);
      step();
      check("ld_memory_op", rd_memory_op, 1);
      dec_ena = 0; dec_nop = 1;
      step();
      check("ld_op_bubble", {rd_op, rd_memory_op}, 0);
      check("ld_ex", rd_ex, 7);
      idle();
      step();
      check("ld_mem", rd_mem, 7);
      check("ld_memory_mem", rd_memory_mem, 1);
      check("ld_stall", stall_cycles, 1);
      check("ld_bubble", bubble_count, 1);

      // 4: OP stall holds OP and bubbles EX
      do_reset();
      issue(9, 1, 0);
      step();
      issue(3, 1, 0);
      step();
      check("ops_pre_ex", rd_ex, 9);
      issue(12, 1, 0);
      op_ena = 0; op_nop = 1;
      step();
      idle();
      check("ops_op_hold", rd_op, 3);
      check("ops_ex_bubble", {rd_ex, rd_used_ex}, 0);
      check("ops_mem", rd_mem, 9);
      check("ops_bubble", bubble_count, 1);
      check("ops_stall", stall_cycles, 0);

      // 5: flush beats a deasserted enable
      do_reset();
      issue(6, 1, 0);
      step();
      issue(4, 1, 0);
      step();
      check("fl_pre", {rd_op, rd_ex}, {5'd4, 5'd6});
      idle();
      flush = 1; op_ena = 0;
      step();
      idle();
      check("fl_op", {rd_op, rd_used_op}, 0);
      check("fl_ex", {rd_ex, rd_used_ex}, 0);
      check("fl_mem", rd_mem, 6);

      // 6a: x0 destination never writes back
      do_reset();
      issue(0, 1, 0);
      step();
      idle();
      step();
      check("x0_used_ex", rd_used_ex, 1);
      step();
      step();
      check("x0_we", rd_we_wb, 0);

      // 6b: counter saturation
      do_reset();
      dec_ena = 0; dec_nop = 1; op_nop = 1;
      for (int i = 0; i < 20; i++) step();
      check("sat_stall32", stall_cycles, 20);
      check("sat_bubble32", bubble_count, 40);
      check("sat_stall4", s_stall, 15);
      check("sat_bubble4", s_bubble, 15);

      // reset mid-stall clears counters, then counting resumes
      rst = 1;
      step();
      check("midrst_cnt", {s_stall, s_bubble, stall_cycles}, 0);
      rst = 0;
      step();
      check("midrst_resume", stall_cycles, 1);
      check("midrst_tags", {rd_op, rd_ex, rd_mem, rd_wb}, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
